// File: rtl/hazard_scoreboard.sv
// Hazard unit for the F/D/E/M/W pipeline: M/W->E forwarding, load-use, memory-wait and branch stall/flush,
// register scoreboard for long-latency ops, and saturating stall/flush cycle counters. Outputs are combinational.
module hazard_scoreboard #(
   parameter int REG_AW   = 5,
   parameter int MAX_LONG = 4,
   parameter int CNT_W    = 16
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [REG_AW-1:0]       rs1_D,
   input  logic [REG_AW-1:0]       rs2_D,
   input  logic [REG_AW-1:0]       rd_D,
   input  logic                    long_op_D,
   input  logic [REG_AW-1:0]       rs1_E,
   input  logic [REG_AW-1:0]       rs2_E,
   input  logic [REG_AW-1:0]       rd_E,
   input  logic [1:0]              rf_wr_sel_E,
   input  logic                    long_op_E,
   input  logic                    pcSource_E,
   input  logic [REG_AW-1:0]       rd_M,
   input  logic [REG_AW-1:0]       rd_W,
   input  logic                    regWrite_M,
   input  logic                    regWrite_W,
   input  logic                    long_done,
   input  logic [REG_AW-1:0]       long_rd,
   input  logic                    memValid1,
   input  logic                    memValid2,
   output logic [1:0]              forwardA_E,
   output logic [1:0]              forwardB_E,
   output logic                    stall_F,
   output logic                    stall_D,
   output logic                    stall_E,
   output logic                    stall_M,
   output logic                    stall_W,
   output logic                    flush_F,
   output logic                    flush_D,
   output logic                    flush_E,
   output logic                    flush_M,
   output logic                    flush_W,
   output logic [(2**REG_AW)-1:0]  busy_q,
   output logic [3:0]              long_cnt,
   output logic [CNT_W-1:0]        stall_cycles,
   output logic [CNT_W-1:0]        flush_cycles
);

   localparam int         NREG       = 2**REG_AW;
   localparam logic [3:0] MAX_LONG_C = 4'(MAX_LONG);

   logic [NREG-1:0]  r_busy;
   logic [3:0]       r_long_cnt;
   logic [CNT_W-1:0] r_stall_cnt;
   logic [CNT_W-1:0] r_flush_cnt;

   logic            w_mem_wait;
   logic            w_load;
   logic            w_sb_hz;
   logic            w_cap_hz;
   logic            w_hold_D;
   logic            w_issue;
   logic            w_done_eff;
   logic            w_set_en;
   logic            w_clr_en;
   logic [NREG-1:0] w_busy_nxt;

   // Forwarding: M is the younger producer, so it beats W.
   always_comb begin
      forwardA_E = 2'b00;
      if (regWrite_M && rs1_E == rd_M && rs1_E != '0)
         forwardA_E = 2'b01;
      else if (regWrite_W && rs1_E == rd_W && rs1_E != '0)
         forwardA_E = 2'b10;

      forwardB_E = 2'b00;
      if (regWrite_M && rs2_E == rd_M && rs2_E != '0)
         forwardB_E = 2'b01;
      else if (regWrite_W && rs2_E == rd_W && rs2_E != '0)
         forwardB_E = 2'b10;
   end

   assign w_mem_wait = ~memValid1 | ~memValid2;
   assign w_load     = (rf_wr_sel_E == 2'b10) && (rd_E != '0) &&
                       ((rs1_D == rd_E) || (rs2_D == rd_E));
   assign w_sb_hz    = r_busy[rs1_D] | r_busy[rs2_D] | (r_busy[rd_D] && (rd_D != '0));
   assign w_cap_hz   = long_op_D && (r_long_cnt == MAX_LONG_C);
   assign w_hold_D   = w_load | w_sb_hz | w_cap_hz;

   assign stall_F = w_hold_D | w_mem_wait;
   assign stall_D = stall_F;
   assign stall_E = w_mem_wait;
   assign stall_M = w_mem_wait;
   assign stall_W = w_mem_wait;

   // A memory wait freezes E in place rather than replacing it with a bubble.
   assign flush_D = pcSource_E | reset;
   assign flush_E = ((w_hold_D | pcSource_E) & ~w_mem_wait) | reset;
   assign flush_F = reset;
   assign flush_M = reset;
   assign flush_W = reset;

   assign w_issue    = long_op_E & ~stall_E & ~flush_E & ~reset;
   assign w_done_eff = long_done && (r_long_cnt != 4'd0);
   assign w_set_en   = w_issue && (rd_E != '0);
   assign w_clr_en   = long_done && (long_rd != '0);

   // Set is applied after clear so a fresh issue supersedes a completing op on the same register.
   always_comb begin
      w_busy_nxt = r_busy;
      for (int i = 1; i < NREG; i++) begin
         if (w_clr_en && long_rd == REG_AW'(i))
            w_busy_nxt[i] = 1'b0;
         if (w_set_en && rd_E == REG_AW'(i))
            w_busy_nxt[i] = 1'b1;
      end
      w_busy_nxt[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_busy      <= '0;
         r_long_cnt  <= 4'd0;
         r_stall_cnt <= '0;
         r_flush_cnt <= '0;
      end else begin
         r_busy <= w_busy_nxt;

         case ({w_issue, w_done_eff})
            2'b10:   r_long_cnt <= r_long_cnt + 4'd1;
            2'b01:   r_long_cnt <= r_long_cnt - 4'd1;
            default: r_long_cnt <= r_long_cnt;
         endcase

         if (stall_F && r_stall_cnt != '1)
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
         if (pcSource_E && r_flush_cnt != '1)
            r_flush_cnt <= r_flush_cnt + CNT_W'(1);
      end
   end

   assign busy_q       = r_busy;
   assign long_cnt     = r_long_cnt;
   assign stall_cycles = r_stall_cnt;
   assign flush_cycles = r_flush_cnt;

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Next-generation hazard unit for the 5-stage pipeline (F/D/E/M/W).
- Forwards results from the M and W stages to E.
- Generates stall/flush controls for load-use hazards, memory-wait stalls and taken branches.
- Adds a register scoreboard for variable-latency operations (divider/multiplier) and saturating performance counters for stall and flush cycles.

Parameters:
- REG_AW, 5, register address width; the scoreboard has 2**REG_AW entries, and entry 0 is never set.
- MAX_LONG, 4, maximum outstanding long-latency operations (1..15).
- CNT_W, 16, width of the saturating performance counters.

Ports:
- clk  in  1  pipeline clock.
- reset  in  1  synchronous, active-high reset.
- rs1_D, rs2_D, rd_D  in  REG_AW  decode-stage source/destination registers.
- long_op_D  in  1  instruction in D is long-latency.
- rs1_E, rs2_E, rd_E  in  REG_AW  execute-stage registers.
- rf_wr_sel_E  in  2  E writeback select; 2'b10 = load.
- long_op_E  in  1  instruction in E is long-latency (issues to unit).
- pcSource_E  in  1  taken branch/jump resolved in E.
- rd_M, rd_W  in  REG_AW  M/W destination registers.
- regWrite_M, regWrite_W  in  1  M/W write enables.
- long_done  in  1  long unit completes this cycle (result enters W).
- long_rd  in  REG_AW  destination of completing op.
- memValid1, memValid2  in  1  imem/dmem ready.
- forwardA_E, forwardB_E  out  2  00 = regfile/E, 01 = M, 10 = W.
- stall_F, stall_D, stall_E, stall_M, stall_W  out  1  stage hold.
- flush_F, flush_D, flush_E, flush_M, flush_W  out  1  stage bubble.
- busy_q  out  2**REG_AW  scoreboard state (debug).
- long_cnt  out  4  outstanding long ops.
- stall_cycles, flush_cycles  out  CNT_W  saturating counters.

Behaviour:
- Forwarding (comb):
  - forwardA_E = 01 if rs1_E==rd_M && regWrite_M && rs1_E!=0.
  - Otherwise 10 if rs1_E==rd_W && regWrite_W && rs1_E!=0.
  - Otherwise 00. M has priority over W.
  - forwardB_E is identical, using rs2_E.
- mem_wait = ~memValid1 | ~memValid2.
- load = rf_wr_sel_E==2'b10 && rd_E!=0 && (rs1_D==rd_E || rs2_D==rd_E).
- sb_hz = busy_q[rs1_D] | busy_q[rs2_D] | (busy_q[rd_D] && rd_D!=0). The rd_D term is the WAW check.
- cap_hz = long_op_D && (long_cnt == MAX_LONG).
- hold_D = load | sb_hz | cap_hz.
- Stall and flush equations:
  - stall_F = stall_D = hold_D | mem_wait.
  - stall_E = stall_M = stall_W = mem_wait.
  - flush_D = pcSource_E | reset.
  - flush_E = ((hold_D | pcSource_E) & ~mem_wait) | reset. mem_wait suppresses bubble insertion so E is frozen, not cleared.
  - flush_F = flush_M = flush_W = reset.
- Issue: issue = long_op_E & ~stall_E & ~flush_E & ~reset.
- Scoreboard, updated on clk:
  - On issue with rd_E!=0: busy_q[rd_E] <= 1.
  - On long_done with long_rd!=0: busy_q[long_rd] <= 0.
  - Same register set and cleared in one cycle: set wins (new op supersedes).
  - A clear is visible to D only the next cycle. D stalls in the completion cycle; the result then comes from the regfile or W forwarding.
- long_cnt counts independently of busy_q (rd==0 ops still count):
  - +1 on issue, -1 on long_done, unchanged when both occur.
  - long_done at long_cnt==0 is ignored (no underflow).
- Counters, updated on clk:
  - stall_cycles += 1 when stall_F is high.
  - flush_cycles += 1 when pcSource_E && !reset.
  - Both saturate at all-ones.
- Reset (synchronous, when reset=1 at the clk edge): busy_q = 0, long_cnt = 0, stall_cycles = 0, flush_cycles = 0.
  - While reset is high: all flush_* = 1, no issue.
  - Stalls and forwards follow their combinational equations.
  - Reset during outstanding long ops discards them. A late long_done after reset is ignored because long_cnt==0.
- Latency:
  - All hazard outputs are combinational from inputs and registered state.
  - State changes take effect one cycle after the enabling edge.

Test Plan:
- Forwarding priority: rd_M=rd_W=5, regWrite_M=regWrite_W=1, rs1_E=5 -> forwardA_E=01. Drop regWrite_M -> 10. rs1_E=0 -> 00.
- Load-use: rf_wr_sel_E=10, rd_E=7, rs2_D=7 -> stall_F=stall_D=1, flush_E=1 for one cycle. Next cycle, forwardB_E=01 from M.
- Scoreboard: issue long op rd_E=9. Next cycle busy_q[9]=1, long_cnt=1. D with rs1_D=9 stalls until one cycle after long_done, long_rd=9; then busy_q[9]=0, long_cnt=0.
- Capacity and WAW: with MAX_LONG=4, issue 4 long ops to x1..x4; a fifth long_op_D stalls with cap_hz. Any D with rd_D=3 stalls with the WAW hazard. One long_done releases the cap stall next cycle.
- Simultaneous set/clear: issue to rd_E=6 in the same cycle as long_done, long_rd=6 -> busy_q[6]=1, long_cnt unchanged.
- Memory wait plus branch plus reset: memValid2=0 with pcSource_E=1 -> all stalls=1, flush_D=1, flush_E=0. Counters increment. Asserting reset mid-operation clears busy_q/long_cnt/counters to 0 and sets all flush_*=1. Drive the counters to all-ones to check saturation.
